// File: rtl/bcp_scheduler.sv
// bcp_scheduler: sequences one BCP propagation round.
// A decision literal is written to the assignment store and issued to the engine. Implications
// reported by the engine are queued in a circular FIFO and then popped, assigned and issued in
// turn. The round ends when the queue drains, the engine reports a conflict, or the queue
// overflows.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   start                 one-cycle pulse that starts a round with dec_var/dec_val
//   eng_en, eng_addr      one-cycle engine enable and the current literal's variable
//   eng_finish            engine idle flag; eng_conflict is valid on its rising cycle
//   eng_impl_*            implied literal reported by the engine
//   assign_we/var/val     one-cycle write strobe to the assignment store
//   busy, done            round in progress; one-cycle end-of-round pulse
//   conflict, overflow    round outcome, held until the next accepted start
//   prop_count            literals issued this round (saturating)
module bcp_scheduler #(
  parameter int unsigned VAR_W  = 8,
  parameter int unsigned QDEPTH = 8,
  parameter int unsigned QPTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [VAR_W-1:0] dec_var,
  input  logic             dec_val,
  output logic             eng_en,
  output logic [VAR_W-1:0] eng_addr,
  input  logic             eng_finish,
  input  logic             eng_impl_valid,
  input  logic [VAR_W-1:0] eng_impl_var,
  input  logic             eng_impl_val,
  input  logic             eng_conflict,
  output logic             assign_we,
  output logic [VAR_W-1:0] assign_var,
  output logic             assign_val,
  output logic             busy,
  output logic             done,
  output logic             conflict,
  output logic             overflow,
  output logic [7:0]       prop_count
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitLow, StWaitHigh, StPop, StFinish
  } state_e;

  localparam logic [QPTR_W:0] QFull = (QPTR_W + 1)'(QDEPTH);

  state_e              state_q;
  logic [QPTR_W-1:0]   head_q, tail_q;
  logic [QPTR_W:0]     count_q;
  logic [VAR_W-1:0]    cur_var_q;
  logic                cur_val_q;
  logic [VAR_W:0]      queue_mem [QDEPTH];

  logic capture, push_ok, push_ovf;

  always_comb begin
    capture  = ((state_q == StWaitLow) || (state_q == StWaitHigh)) && eng_impl_valid;
    push_ok  = capture && (count_q != QFull);
    push_ovf = capture && (count_q == QFull);
  end

  // Entry storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      queue_mem[tail_q] <= {eng_impl_val, eng_impl_var};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cur_var_q  <= '0;
      cur_val_q  <= 1'b0;
      eng_en     <= 1'b0;
      eng_addr   <= '0;
      assign_we  <= 1'b0;
      assign_var <= '0;
      assign_val <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      conflict   <= 1'b0;
      overflow   <= 1'b0;
      prop_count <= '0;
    end else begin
      eng_en    <= 1'b0;
      assign_we <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_var_q  <= dec_var;
            cur_val_q  <= dec_val;
            assign_we  <= 1'b1;
            assign_var <= dec_var;
            assign_val <= dec_val;
            conflict   <= 1'b0;
            overflow   <= 1'b0;
            prop_count <= '0;
            busy       <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          // Enable lands one cycle after the assign strobe so the two never overlap.
          eng_en   <= 1'b1;
          eng_addr <= cur_var_q;
          if (prop_count != 8'hFF) prop_count <= prop_count + 8'd1;
          state_q  <= StWaitLow;
        end
        StWaitLow, StWaitHigh: begin
          if (push_ovf) begin
            // Overflow aborts the round; the engine's eventual result is ignored.
            overflow <= 1'b1;
            head_q   <= tail_q;
            count_q  <= '0;
            done     <= 1'b1;
            state_q  <= StFinish;
          end else if (state_q == StWaitHigh && eng_finish && eng_conflict) begin
            conflict <= 1'b1;
            head_q   <= tail_q;
            count_q  <= '0;
            done     <= 1'b1;
            state_q  <= StFinish;
          end else begin
            if (push_ok) begin
              tail_q  <= tail_q + QPTR_W'(1);
              count_q <= count_q + 1'b1;
            end
            if (state_q == StWaitLow) begin
              if (!eng_finish) state_q <= StWaitHigh;
            end else if (eng_finish) begin
              // A push on the rising cycle counts toward the empty test.
              if (count_q == '0 && !push_ok) begin
                done    <= 1'b1;
                state_q <= StFinish;
              end else begin
                state_q <= StPop;
              end
            end
          end
        end
        StPop: begin
          cur_var_q  <= queue_mem[head_q][VAR_W-1:0];
          cur_val_q  <= queue_mem[head_q][VAR_W];
          assign_we  <= 1'b1;
          assign_var <= queue_mem[head_q][VAR_W-1:0];
          assign_val <= queue_mem[head_q][VAR_W];
          head_q     <= head_q + QPTR_W'(1);
          count_q    <= count_q - 1'b1;
          state_q    <= StIssue;
        end
        StFinish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_scheduler.sv
// Randomized bench for bcp_scheduler. A scripted engine answers each eng_en according to a
// per-round script; a FIFO-level reference model derives the expected assign/issue sequences.
module tb_bcp_scheduler;

  localparam int MaxK = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dec_var = '0;
  logic       dec_val = 1'b0;
  logic       eng_en;
  logic [7:0] eng_addr;
  logic       eng_finish = 1'b1;
  logic       eng_impl_valid = 1'b0;
  logic [7:0] eng_impl_var = '0;
  logic       eng_impl_val = 1'b0;
  logic       eng_conflict = 1'b0;
  logic       assign_we;
  logic [7:0] assign_var;
  logic       assign_val;
  logic       busy, done, conflict, overflow;
  logic [7:0] prop_count;

  bcp_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .dec_var(dec_var), .dec_val(dec_val),
    .eng_en(eng_en), .eng_addr(eng_addr), .eng_finish(eng_finish),
    .eng_impl_valid(eng_impl_valid), .eng_impl_var(eng_impl_var),
    .eng_impl_val(eng_impl_val), .eng_conflict(eng_conflict),
    .assign_we(assign_we), .assign_var(assign_var), .assign_val(assign_val),
    .busy(busy), .done(done), .conflict(conflict), .overflow(overflow),
    .prop_count(prop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine script, indexed by issue number within the round.
  int         nimp  [MaxK];
  logic [7:0] ivar  [MaxK][10];
  logic       ival  [MaxK][10];
  logic       conf  [MaxK];
  logic       rlast [MaxK];
  int         extra [MaxK];
  int         issue_idx = 0;

  task automatic clear_script();
    for (int k = 0; k < MaxK; k++) begin
      nimp[k] = 0; conf[k] = 1'b0; rlast[k] = 1'b0; extra[k] = 0;
      for (int j = 0; j < 10; j++) begin
        ivar[k][j] = 8'($urandom); ival[k][j] = 1'($urandom);
      end
    end
  endtask

  // Scripted engine: holds finish high one extra cycle after en, drops it for a few cycles
  // while reporting implications, then raises it with the scripted conflict flag.
  int   e_phase = 0;
  int   e_k, e_n, e_pl, e_low, e_i;
  logic e_rl, e_cf;

  initial begin
    forever begin
      @(negedge clock);
      eng_impl_valid = 1'b0;
      eng_conflict   = 1'b0;
      if (!reset) begin
        e_phase = 0;
        eng_finish = 1'b1;
      end else begin
        case (e_phase)
          0: begin
            eng_finish = 1'b1;
            if (eng_en) begin
              e_k = issue_idx;
              issue_idx++;
              e_n  = (e_k < MaxK) ? nimp[e_k] : 0;
              e_rl = (e_k < MaxK) ? (rlast[e_k] && e_n > 0) : 1'b0;
              e_cf = (e_k < MaxK) ? conf[e_k] : 1'b0;
              e_pl = e_n - (e_rl ? 1 : 0);
              e_low = e_pl + ((e_k < MaxK) ? extra[e_k] : 0);
              if (e_low < 1) e_low = 1;
              e_i = 0;
              e_phase = 1;
            end
          end
          1: e_phase = 2;
          2: begin
            eng_finish = 1'b0;
            if (e_i < e_pl) begin
              eng_impl_valid = 1'b1;
              eng_impl_var = ivar[e_k][e_i];
              eng_impl_val = ival[e_k][e_i];
            end
            e_i++;
            if (e_i >= e_low) e_phase = 3;
          end
          default: begin
            eng_finish = 1'b1;
            eng_conflict = e_cf;
            if (e_rl) begin
              eng_impl_valid = 1'b1;
              eng_impl_var = ivar[e_k][e_n-1];
              eng_impl_val = ival[e_k][e_n-1];
            end
            e_phase = 0;
          end
        endcase
      end
    end
  end

  // Output monitors, sampled on the falling edge.
  logic [8:0] got_assign [$];
  logic [7:0] got_addr   [$];
  int         done_cnt = 0;
  int         both_cnt = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (assign_we) got_assign.push_back({assign_val, assign_var});
      if (eng_en) got_addr.push_back(eng_addr);
      if (done) done_cnt++;
      if (eng_en && assign_we) both_cnt++;
    end
  end

  // Reference model: FIFO of literals, applied issue by issue.
  logic [8:0] exp_assign [$];
  logic [7:0] exp_addr   [$];
  logic       exp_conf, exp_ovf;
  int         exp_prop;

  task automatic model(input logic [7:0] v, input logic b);
    logic [8:0] q [$];
    logic [8:0] cur;
    int k, n;
    exp_assign.delete(); exp_addr.delete();
    exp_conf = 1'b0; exp_ovf = 1'b0; exp_prop = 0;
    cur = {b, v};
    exp_assign.push_back(cur);
    k = 0;
    forever begin
      exp_addr.push_back(cur[7:0]);
      if (exp_prop < 255) exp_prop++;
      n = (k < MaxK) ? nimp[k] : 0;
      for (int j = 0; j < n; j++) begin
        if (q.size() == 8) begin
          exp_ovf = 1'b1;
          break;
        end
        q.push_back({ival[k][j], ivar[k][j]});
      end
      if (exp_ovf) break;
      if (k < MaxK && conf[k]) begin
        exp_conf = 1'b1;
        break;
      end
      if (q.size() == 0) break;
      cur = q.pop_front();
      exp_assign.push_back(cur);
      k++;
    end
  endtask

  task automatic run_round(input string tag, input logic [7:0] v, input logic b);
    int a_base, e_base, d_base, x_base, cyc;
    model(v, b);
    cyc = 0;
    while (e_phase != 0 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    issue_idx = 0;
    a_base = got_assign.size(); e_base = got_addr.size();
    d_base = done_cnt; x_base = both_cnt;
    start = 1'b1; dec_var = v; dec_val = b;
    @(negedge clock);
    start = 1'b0;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    check({tag, ".ovf_clear"}, 32'(overflow), 32'd0);
    cyc = 0;
    while (done_cnt == d_base && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, ".done_seen"}, 32'(cyc < 5000), 32'd1);
    repeat (3) @(negedge clock);
    check({tag, ".done_cnt"}, 32'(done_cnt - d_base), 32'd1);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".conflict"}, 32'(conflict), 32'(exp_conf));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".prop_count"}, 32'(prop_count), 32'(exp_prop));
    check({tag, ".n_assign"}, 32'(got_assign.size() - a_base), 32'(exp_assign.size()));
    check({tag, ".n_issue"}, 32'(got_addr.size() - e_base), 32'(exp_addr.size()));
    check({tag, ".en_we_overlap"}, 32'(both_cnt - x_base), 32'd0);
    for (int i = 0; i < exp_assign.size(); i++)
      if (a_base + i < got_assign.size())
        check({tag, ".assign"}, 32'(got_assign[a_base+i]), 32'(exp_assign[i]));
    for (int i = 0; i < exp_addr.size(); i++)
      if (e_base + i < got_addr.size())
        check({tag, ".eng_addr"}, 32'(got_addr[e_base+i]), 32'(exp_addr[i]));
  endtask

  task automatic random_script();
    int len;
    clear_script();
    len = $urandom_range(1, 10);
    for (int k = 0; k < len; k++) begin
      nimp[k]  = $urandom_range(0, 3);
      conf[k]  = ($urandom_range(0, 11) == 0);
      rlast[k] = 1'($urandom);
      extra[k] = $urandom_range(0, 2);
    end
    if ($urandom_range(0, 7) == 0) nimp[0] = 9;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({eng_en, eng_addr, assign_we, assign_var, assign_val, busy, done, conflict,
                overflow, prop_count});
  endfunction

  initial begin
    int d_base, e_base, cyc;
    clear_script();
    repeat (3) @(negedge clock);
    check("reset.outputs", all_outs(), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single decision, no implications.
    clear_script();
    run_round("t1", 8'd5, 1'b1);

    // Two implications popped in FIFO order.
    clear_script();
    nimp[0] = 2;
    ivar[0][0] = 8'd7; ival[0][0] = 1'b0;
    ivar[0][1] = 8'd3; ival[0][1] = 1'b1;
    run_round("t2", 8'd2, 1'b1);

    // Conflict with an implication pending.
    clear_script();
    nimp[0] = 1; conf[0] = 1'b1;
    run_round("t3", 8'd4, 1'b0);

    // Nine implications overflow the eight-entry queue.
    clear_script();
    nimp[0] = 9;
    run_round("t4", 8'd9, 1'b1);

    // Overflow cleared by the next start; also a push on the rising cycle.
    clear_script();
    nimp[0] = 2; rlast[0] = 1'b1;
    run_round("t5", 8'd11, 1'b0);

    // Random rounds; pointers wrap across rounds.
    for (int r = 0; r < 40; r++) begin
      random_script();
      run_round("rnd", 8'($urandom), 1'($urandom));
    end

    // Reset while waiting on the engine with three entries queued.
    clear_script();
    nimp[0] = 3; extra[0] = 8;
    cyc = 0;
    while (e_phase != 0 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    issue_idx = 0;
    e_base = got_addr.size();
    start = 1'b1; dec_var = 8'd20; dec_val = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (got_addr.size() == e_base && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_mid.issued", 32'(cyc < 50), 32'd1);
    repeat (6) @(negedge clock);
    check("rst_mid.busy_before", 32'(busy), 32'd1);
    d_base = done_cnt;
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid.outputs", all_outs(), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("rst_mid.no_done", 32'(done_cnt - d_base), 32'd0);
    check("rst_mid.idle", 32'(busy), 32'd0);

    // Clean round after reset.
    clear_script();
    nimp[0] = 2; nimp[1] = 1;
    run_round("after_rst", 8'd33, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcp_scheduler.md
Name: bcp_scheduler

Overview:
Sequences the BCP engine for one propagation round. It accepts a decision literal and writes it to the assignment store. It then issues the literal's watch address to the engine and collects the implications the engine reports into an internal circular implication queue. Queued literals are popped, assigned and issued in turn until the queue drains, a conflict is reported, or the queue overflows. It sits between the decision unit and bcp_engine / clause_db.

Parameters:
VAR_W, 8, width of variable index and engine access address
QDEPTH, 8, implication queue depth (power of 2)
QPTR_W, 3, log2(QDEPTH)

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin propagation of decision literal
dec_var  in  VAR_W  decision variable index
dec_val  in  1  decision polarity
eng_en  out  1  one-cycle enable to BCP engine
eng_addr  out  VAR_W  access address for the engine (current literal's variable)
eng_finish  in  1  engine idle/finish flag (high when idle)
eng_impl_valid  in  1  engine reports an implied literal this cycle
eng_impl_var  in  VAR_W  implied variable
eng_impl_val  in  1  implied polarity
eng_conflict  in  1  conflict flag, sampled when eng_finish rises
assign_we  out  1  one-cycle write strobe to assignment store
assign_var  out  VAR_W  variable being assigned
assign_val  out  1  value being assigned
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of round
conflict  out  1  round ended in conflict; held until next start
overflow  out  1  round aborted on queue overflow; held until next start
prop_count  out  8  literals issued this round, saturates at 255

Behaviour:
- Reset (async, active-low): state=IDLE; queue head=tail=count=0. All outputs are 0: eng_en, eng_addr, assign_we, assign_var, assign_val, busy, done, conflict, overflow, prop_count. Reset mid-round abandons the round silently with no done pulse.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, POP, FINISH.
- IDLE: on start, the same edge latches cur=dec_var/dec_val and clears conflict, overflow and prop_count. assign_we=1 with dec_var/dec_val is registered, i.e. high for the cycle after start. Next state is ISSUE. start in any other state is ignored.
- ISSUE (1 cycle): eng_en=1, eng_addr=cur_var; prop_count+1 (saturating); go to WAIT_LOW.
- WAIT_LOW: wait for eng_finish=0 (engine accepted). eng_finish stays high for its first cycle after en, so a high eng_finish here is not completion.
- WAIT_HIGH: wait for eng_finish=1. On the rising cycle:
  - if eng_conflict=1: set conflict, flush queue (head=tail, count=0), go to FINISH;
  - else if count=0: go to FINISH;
  - else go to POP.
- Implication capture in WAIT_LOW and WAIT_HIGH: each eng_impl_valid cycle pushes {var,val} at tail; tail wraps modulo QDEPTH.
  - Push while count=QDEPTH: entry dropped, overflow=1, queue flushed, go to FINISH immediately; the engine result is ignored.
  - Push on the same cycle eng_finish rises: the entry is counted before the empty test, so the transition goes to POP.
  - No deduplication; the assignment store is responsible for duplicates.
- POP (1 cycle): read head entry into cur. assign_we=1 with that var/val registered on the same edge. head+1 (wraps), count-1. Go to ISSUE.
- FINISH (1 cycle): done=1; go to IDLE. conflict and overflow remain valid until the next accepted start.
- eng_en and assign_we are never high in the same cycle. Every literal costs at least 4 cycles plus engine latency.

Test Plan:
- Decision var=5 val=1, engine finishes with no implications -> assign_we once (5,1), one eng_en with eng_addr=5, done pulse, conflict=0, prop_count=1.
- Decision var=2; engine reports implications (7,0) and (3,1), each later issue reports none -> assign_we sequence (2,1),(7,0),(3,1); eng_addr sequence 2,7,3 in FIFO order; prop_count=3, done once.
- Decision var=4, engine finishes with eng_conflict=1 while one implication is pending -> no further eng_en, queue count=0, conflict=1, done pulse.
- QDEPTH=8; engine emits 9 implications in one check -> overflow=1 on the 9th, done pulse, no POP; a following start clears overflow.
- Implications spread across rounds exceed 8 cumulative entries -> tail and head wrap past index 7 and literals pop in correct order.
- Reset asserted during WAIT_HIGH with 3 queued entries -> all outputs 0, state IDLE, no done; a new start runs a clean round.
